// File: rtl/ssd_pkg.sv
// Shared constants, slot type and small decode helpers for the seven-segment scan scheduler.
package ssd_pkg;

  localparam logic [3:0] SSD_AN0 = 4'b0111;
  localparam logic [3:0] SSD_AN1 = 4'b1011;
  localparam logic [3:0] SSD_AN2 = 4'b1101;
  localparam logic [3:0] SSD_AN3 = 4'b1110;
  localparam logic [3:0] SSD_OFF = 4'b1111;

  localparam int unsigned SCAN_DIV_DEF  = 50000;
  localparam int unsigned BLANK_CYC_DEF = 500;

  typedef logic [1:0] slot_t;

  function automatic logic [3:0] slot_anode(slot_t s);
    logic [3:0] an;
    unique case (s)
      2'd0: an = SSD_AN0;
      2'd1: an = SSD_AN1;
      2'd2: an = SSD_AN2;
      2'd3: an = SSD_AN3;
    endcase
    return an;
  endfunction

  // Slot 0 is the leftmost digit, held in the most significant nibble.
  function automatic logic [3:0] slot_nibble(logic [15:0] v, slot_t s);
    logic [3:0] nib;
    unique case (s)
      2'd0: nib = v[15:12];
      2'd1: nib = v[11:8];
      2'd2: nib = v[7:4];
      2'd3: nib = v[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/ssd_scan_sched_if.sv
// Valid/ready update channel carrying a display value and digit-enable mask.
interface ssd_scan_sched_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_val;
  logic [3:0]  upd_en;

  modport master (output upd_valid, output upd_val, output upd_en, input upd_ready);
  modport slave  (input upd_valid, input upd_val, input upd_en, output upd_ready);
endinterface

// File: rtl/ssd_slot_timer.sv
// Digit-slot timer: cycle counter within a slot plus the 2-bit slot index.
// Exposes next-state views so the caller can register outputs with no lag.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  output slot_t slot_nxt,
  output logic  in_blank_nxt,
  output logic  frame_wrap
);

  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BlankCyc = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            slot_q, slot_d;
  logic             cnt_wrap;

  always_comb begin
    cnt_wrap     = (cnt_q == CntMax);
    cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
    slot_d       = cnt_wrap ? slot_q + 2'd1 : slot_q;
    frame_wrap   = cnt_wrap && (slot_q == 2'd3);
    slot_nxt     = slot_d;
    in_blank_nxt = (cnt_d < BlankCyc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/ssd_scan_sched.sv
// Four-digit seven-segment scan scheduler with double-buffered value/mask that
// swaps only at frame boundaries, plus per-slot anti-ghosting blanking.
module ssd_scan_sched
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ssd_scan_sched_if.slave     upd,
  output slot_t               ssd_ctl_en,
  output logic [3:0]          ssd_ctl,
  output logic [3:0]          ssd_in,
  output logic                frame_start
);

  slot_t       slot_nxt;
  logic        in_blank_nxt;
  logic        frame_wrap;

  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_en_q, act_en_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_en_q, pend_en_d;
  logic        pend_valid_q, pend_valid_d;
  logic        xfer, swap;
  logic [3:0]  ctl_d, in_d;

  ssd_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_nxt     (slot_nxt),
    .in_blank_nxt (in_blank_nxt),
    .frame_wrap   (frame_wrap)
  );

  assign upd.upd_ready = !pend_valid_q;

  always_comb begin
    xfer         = upd.upd_valid && !pend_valid_q;
    swap         = frame_wrap && pend_valid_q;
    act_val_d    = swap ? pend_val_q : act_val_q;
    act_en_d     = swap ? pend_en_q : act_en_q;
    // A transfer only happens with pending empty, so it never races a swap.
    pend_valid_d = xfer || (pend_valid_q && !swap);
    pend_val_d   = xfer ? upd.upd_val : pend_val_q;
    pend_en_d    = xfer ? upd.upd_en : pend_en_q;
    // Mask bit 3 belongs to slot 0, so the mask index is the inverted slot.
    ctl_d        = (in_blank_nxt || !act_en_d[~slot_nxt]) ? SSD_OFF : slot_anode(slot_nxt);
    in_d         = slot_nibble(act_val_d, slot_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_q    <= '0;
      act_en_q     <= '0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      ssd_ctl_en   <= '0;
      ssd_ctl      <= SSD_OFF;
      ssd_in       <= '0;
      frame_start  <= 1'b0;
    end else begin
      act_val_q    <= act_val_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      ssd_ctl_en   <= slot_nxt;
      ssd_ctl      <= ctl_d;
      ssd_in       <= in_d;
      frame_start  <= frame_wrap;
    end
  end

endmodule
